conv_transconv_tile_sequencer: RTL
==================================

Name: conv_transconv_tile_sequencer

Overview:
Parametrised tile sequencer that drives the conv/transconv datapath top level on its own, replacing per-cycle external control of weight/ifmap BRAM reads and output writes. A single start command runs the whole layer. The block then generates start pulses, BRAM read enables and addresses, the transconv ifmap bank rotation, and output write strobes for a configurable number of tiles. External output-BRAM readback is arbitrated so that it is granted only while the block is idle.

Parameters:
NUM_BRAMS, 16, number of BRAM banks / PE columns; power of 2, minimum 2
W_ADDR_W, 11, weight BRAM address width
I_ADDR_W, 10, ifmap BRAM address width
O_ADDR_W, 10, output BRAM address width
LEN_W, 8, width of the tile-count and tile-length config fields
PIPE_LAT, 4, engine drain cycles after the last read of a tile; minimum 1

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle command; sampled only in IDLE
cfg_mode  in  2  00 conv, 01 transconv, 1x illegal
cfg_num_tiles  in  LEN_W  tiles in the layer (T)
cfg_tile_len  in  LEN_W  reads per tile (L)
cfg_w_base  in  W_ADDR_W  weight base address
cfg_if_base  in  I_ADDR_W  ifmap base address
cfg_o_base  in  O_ADDR_W  output base address
stall  in  1  engine backpressure; freezes LOAD/DRAIN
ext_read_req  in  1  external readback request
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of layer
err  out  1  sticky error flag; cleared by next accepted start
start_conv  out  1  one-cycle pulse in PRIME when mode is conv
start_transconv  out  1  one-cycle pulse in PRIME when mode is transconv
w_re_conv  out  NUM_BRAMS  all ones during an active conv LOAD cycle
w_re_transconv  out  NUM_BRAMS  all ones during an active transconv LOAD cycle
w_addr_rd_flat  out  NUM_BRAMS*W_ADDR_W  weight read address, replicated per bank
if_re_conv  out  NUM_BRAMS  bit0 only, during an active conv LOAD cycle
if_re_transconv  out  NUM_BRAMS  all ones during an active transconv LOAD cycle
if_addr_rd_flat  out  NUM_BRAMS*I_ADDR_W  ifmap read address, replicated per bank
ifmap_sel_transconv  out  $clog2(NUM_BRAMS)  ifmap bank rotation index
o_we  out  NUM_BRAMS  all ones in WB
o_addr_wr  out  O_ADDR_W  output write address
ext_read_gnt  out  1  readback grant
tile_idx  out  LEN_W  current tile number

Behaviour:
- Reset: synchronous on clk when rst_n=0. State goes to IDLE and every output is 0, including err. Reset mid-layer aborts the layer immediately, with no done pulse.
- start in IDLE latches all cfg_* inputs and clears err; config changes afterwards are ignored. start in any other state is ignored.
- IDLE -> DONE (err=1) when mode is 1x or L=0.
- IDLE -> DONE (err=0) when T=0.
- Otherwise IDLE -> PRIME.
- PRIME: one cycle; pulses start_conv or start_transconv; -> LOAD with k=0, tile_idx=0.
- LOAD: one read per non-stalled cycle, k counting 0..L-1.
  - conv: weight addr = w_base + tile_idx*L + k; ifmap addr = if_base + k (ifmap is re-streamed each tile).
  - transconv: weight addr = w_base + k; ifmap addr = if_base + tile_idx*L + k.
  - All address sums wrap modulo 2^ADDR_W. The tile_idx*L product is computed at full width, then truncated.
  - ifmap_sel_transconv = k mod NUM_BRAMS in transconv mode, 0 in conv mode.
  - After k=L-1 -> DRAIN.
- DRAIN: counts PIPE_LAT non-stalled cycles; -> WB.
- WB: one cycle; o_we all ones, o_addr_wr = o_base + tile_idx (wraps).
  - If tile_idx = T-1 -> DONE; otherwise tile_idx+1 -> LOAD with k=0.
- DONE: one cycle; done=1 -> IDLE.
- stall=1 in LOAD or DRAIN: counters and addresses hold, all re outputs are 0, state holds. stall is ignored in every other state.
- Read enables are registered and aligned with their addresses in the same cycle.
- ext_read_gnt is registered: it equals ext_read_req from the previous cycle while in IDLE, and is otherwise 0.
  - A start that coincides with a granted read is accepted, and the grant drops in the next cycle.
- Layer latency from the start edge until done: 2 + T*(L+PIPE_LAT+1) cycles with no stalls.

Optional Feature:
SEQ_PERF_CNT_EN
- Defined: adds outputs perf_cycles[31:0] and perf_stalls[31:0].
  - Both are zeroed on an accepted start.
  - perf_cycles increments in every non-IDLE cycle; perf_stalls increments in each stalled LOAD/DRAIN cycle.
  - Both saturate at all ones and hold their value in IDLE.
- Undefined: neither port nor the counters exist; behaviour is otherwise identical.

Test Plan:
- conv, T=2, L=4, PIPE_LAT=3, w_base=0x10, if_base=0, o_base=5 -> start_conv at cycle 1. Weight addrs are 0x10-0x13 (cycles 2-5) and 0x14-0x17 (cycles 10-13). Ifmap addrs 0-3 in both tiles. o_we at cycles 9 and 17 with addrs 5 and 6. done at cycle 18, err=0.
- transconv, NUM_BRAMS=16, T=1, L=20 -> ifmap_sel_transconv counts 0..15 then 0..3. Ifmap addrs are if_base+0..19, weight addrs w_base+0..19.
- Same setup as the first scenario, with stall held for 3 cycles at k=2 of tile 0 -> addr 0x12 is held and re=0 for those 3 cycles. done arrives at cycle 21.
- cfg_mode=2'b10 -> done one cycle after start, with err=1 and no start pulses or reads. A following legal start clears err.
- w_base=0x7FE, T=1, L=4 -> weight addrs 0x7FE, 0x7FF, 0x000, 0x001.
- ext_read_req held high during a layer -> gnt=0 while busy, and gnt=1 from the cycle after DONE. rst_n low mid-LOAD -> all outputs are 0 next cycle and no done pulse occurs.

Source files
------------

// File: rtl/conv_transconv_tile_sequencer.sv
// Tile sequencer for the conv/transconv datapath: one start command runs a whole layer of tiles.
// Defining SEQ_PERF_CNT_EN adds the perf_cycles/perf_stalls counters.
module conv_transconv_tile_sequencer #(
   parameter int NUM_BRAMS = 16,
   parameter int W_ADDR_W  = 11,
   parameter int I_ADDR_W  = 10,
   parameter int O_ADDR_W  = 10,
   parameter int LEN_W     = 8,
   parameter int PIPE_LAT  = 4
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [1:0]                      cfg_mode,
   input  logic [LEN_W-1:0]                cfg_num_tiles,
   input  logic [LEN_W-1:0]                cfg_tile_len,
   input  logic [W_ADDR_W-1:0]             cfg_w_base,
   input  logic [I_ADDR_W-1:0]             cfg_if_base,
   input  logic [O_ADDR_W-1:0]             cfg_o_base,
   input  logic                            stall,
   input  logic                            ext_read_req,
   output logic                            busy,
   output logic                            done,
   output logic                            err,
   output logic                            start_conv,
   output logic                            start_transconv,
   output logic [NUM_BRAMS-1:0]            w_re_conv,
   output logic [NUM_BRAMS-1:0]            w_re_transconv,
   output logic [NUM_BRAMS*W_ADDR_W-1:0]   w_addr_rd_flat,
   output logic [NUM_BRAMS-1:0]            if_re_conv,
   output logic [NUM_BRAMS-1:0]            if_re_transconv,
   output logic [NUM_BRAMS*I_ADDR_W-1:0]   if_addr_rd_flat,
   output logic [$clog2(NUM_BRAMS)-1:0]    ifmap_sel_transconv,
   output logic [NUM_BRAMS-1:0]            o_we,
   output logic [O_ADDR_W-1:0]             o_addr_wr,
   output logic                            ext_read_gnt,
   output logic [LEN_W-1:0]                tile_idx
`ifdef SEQ_PERF_CNT_EN
   ,
   output logic [31:0]                     perf_cycles,
   output logic [31:0]                     perf_stalls
`endif
);

   localparam int SEL_W = $clog2(NUM_BRAMS);
   localparam int PW    = 2 * LEN_W + 1;
   localparam int DW    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   typedef enum logic [2:0] {S_IDLE, S_PRIME, S_LOAD, S_DRAIN, S_WB, S_DONE} state_t;

   state_t               state;
   logic                 mode_tc;
   logic [LEN_W-1:0]     tiles_q;
   logic [LEN_W-1:0]     len_q;
   logic [W_ADDR_W-1:0]  w_base_q;
   logic [I_ADDR_W-1:0]  if_base_q;
   logic [O_ADDR_W-1:0]  o_base_q;
   logic [LEN_W-1:0]     k;
   logic [DW-1:0]        drain_cnt;
   logic [W_ADDR_W-1:0]  w_addr;
   logic [I_ADDR_W-1:0]  if_addr;

   logic                 issue;
   logic [LEN_W-1:0]     iss_tile;
   logic [LEN_W-1:0]     iss_k;
   logic [LEN_W-1:0]     last_tile;
   logic [PW-1:0]        tile_off;
   logic [PW-1:0]        w_off;
   logic [PW-1:0]        i_off;

   assign last_tile       = tiles_q - LEN_W'(1);
   assign busy            = (state != S_IDLE);
   assign w_addr_rd_flat  = {NUM_BRAMS{w_addr}};
   assign if_addr_rd_flat = {NUM_BRAMS{if_addr}};

   // Which read (tile, k) gets presented on the next cycle; PRIME and WB launch k=0 of a tile.
   always_comb begin
      issue    = 1'b0;
      iss_tile = '0;
      iss_k    = '0;
      case (state)
         S_PRIME: issue = 1'b1;
         S_LOAD: begin
            iss_tile = tile_idx;
            iss_k    = k;
            issue    = !stall && (k != len_q);
         end
         S_WB: begin
            iss_tile = tile_idx + LEN_W'(1);
            issue    = (tile_idx != last_tile);
         end
         default: ;
      endcase
      tile_off = PW'(iss_tile) * PW'(len_q);
      w_off    = mode_tc ? PW'(iss_k) : tile_off + PW'(iss_k);
      i_off    = mode_tc ? tile_off + PW'(iss_k) : PW'(iss_k);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state               <= S_IDLE;
         mode_tc             <= 1'b0;
         tiles_q             <= '0;
         len_q               <= '0;
         w_base_q            <= '0;
         if_base_q           <= '0;
         o_base_q            <= '0;
         k                   <= '0;
         drain_cnt           <= '0;
         w_addr              <= '0;
         if_addr             <= '0;
         done                <= 1'b0;
         err                 <= 1'b0;
         start_conv          <= 1'b0;
         start_transconv     <= 1'b0;
         w_re_conv           <= '0;
         w_re_transconv      <= '0;
         if_re_conv          <= '0;
         if_re_transconv     <= '0;
         ifmap_sel_transconv <= '0;
         o_we                <= '0;
         o_addr_wr           <= '0;
         ext_read_gnt        <= 1'b0;
         tile_idx            <= '0;
      end else begin
         done            <= 1'b0;
         start_conv      <= 1'b0;
         start_transconv <= 1'b0;
         w_re_conv       <= '0;
         w_re_transconv  <= '0;
         if_re_conv      <= '0;
         if_re_transconv <= '0;
         o_we            <= '0;
         ext_read_gnt    <= 1'b0;

         case (state)
            S_IDLE: begin
               if (start) begin
                  mode_tc   <= cfg_mode[0];
                  tiles_q   <= cfg_num_tiles;
                  len_q     <= cfg_tile_len;
                  w_base_q  <= cfg_w_base;
                  if_base_q <= cfg_if_base;
                  o_base_q  <= cfg_o_base;
                  err       <= 1'b0;
                  if (cfg_mode[1] || (cfg_tile_len == '0)) begin
                     err   <= 1'b1;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else if (cfg_num_tiles == '0) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     start_conv      <= !cfg_mode[0];
                     start_transconv <= cfg_mode[0];
                     state           <= S_PRIME;
                  end
               end else begin
                  ext_read_gnt <= ext_read_req;
               end
            end
            S_PRIME: begin
               tile_idx <= '0;
               state    <= S_LOAD;
            end
            S_LOAD: begin
               if (!stall && (k == len_q)) begin
                  drain_cnt <= '0;
                  state     <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (!stall) begin
                  if (drain_cnt == DW'(PIPE_LAT - 1)) begin
                     o_we      <= '1;
                     o_addr_wr <= o_base_q + O_ADDR_W'(tile_idx);
                     state     <= S_WB;
                  end else begin
                     drain_cnt <= drain_cnt + DW'(1);
                  end
               end
            end
            S_WB: begin
               if (tile_idx == last_tile) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  tile_idx <= tile_idx + LEN_W'(1);
                  state    <= S_LOAD;
               end
            end
            S_DONE: begin
               ext_read_gnt <= ext_read_req;
               state        <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         // A stalled or finished tile leaves the addresses parked and the enables low.
         if (issue) begin
            k                   <= iss_k + LEN_W'(1);
            w_addr              <= w_base_q + W_ADDR_W'(w_off);
            if_addr             <= if_base_q + I_ADDR_W'(i_off);
            ifmap_sel_transconv <= mode_tc ? SEL_W'(iss_k) : '0;
            w_re_conv           <= mode_tc ? '0 : '1;
            w_re_transconv      <= mode_tc ? '1 : '0;
            if_re_conv          <= mode_tc ? '0 : NUM_BRAMS'(1);
            if_re_transconv     <= mode_tc ? '1 : '0;
         end
      end
   end

`ifdef SEQ_PERF_CNT_EN
   // Saturating counters, zeroed on an accepted start and frozen while idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_cycles <= '0;
         perf_stalls <= '0;
      end else if (state == S_IDLE) begin
         if (start) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
         end
      end else begin
         if (perf_cycles != '1)
            perf_cycles <= perf_cycles + 32'd1;
         if (stall && ((state == S_LOAD) || (state == S_DRAIN)) && (perf_stalls != '1))
            perf_stalls <= perf_stalls + 32'd1;
      end
   end
`endif

endmodule
